decoder_5to32_reg: RTL and testbench

- Registered 5-to-32 one-hot decoder. A 5-bit select code becomes a 32-bit one-hot word, e.g. for register-file write-enable or address-slice selection.
- Optional enable and output-polarity control.
- The block sits between the select-code source and the 32 consumer enables.
- Outputs are registered by default, giving 1-cycle latency.

---
 rtl/decoder_5to32_reg.sv | 73 +++++++
 tb/tb_decoder_5to32_reg.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/decoder_5to32_reg.sv
// Registered 5-to-32 one-hot decoder with enable and selectable output polarity.
// raw is the active-high one-hot word; m is raw, optionally inverted as a whole.
// With REGISTERED=1 the outputs lag sel/en by one clock. With REGISTERED=0 they
// follow sel/en combinationally. In both modes rst_n low forces the deasserted pattern.
module decoder_5to32_reg #(
    parameter bit REGISTERED = 1'b1,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [4:0]  sel,
    output logic [31:0] m,
    output logic        valid
);

    logic [31:0] raw_d;
    logic        valid_d;
    logic [31:0] raw_out;
    logic        valid_out;

    // One comparator per output line. Every sel code is legal, so exactly one
    // line is set while en is high, and no line is set while en is low.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_line
            assign raw_d[gi] = en & (sel == 5'(gi));
        end
    endgenerate

    // valid tracks en directly: a decode is present whenever en is high.
    always_comb begin
        valid_d = en;
    end

    generate
        if (REGISTERED) begin : g_reg
            logic [31:0] raw_q;
            logic        valid_q;

            // Output register. The asynchronous clear means the reset takes effect
            // mid-cycle. The first decode after release appears on the next rising edge.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    raw_q   <= 32'h0000_0000;
                    valid_q <= 1'b0;
                end else begin
                    raw_q   <= raw_d;
                    valid_q <= valid_d;
                end
            end

            assign raw_out   = raw_q;
            assign valid_out = valid_q;
        end else begin : g_comb
            // Combinational path. clk is unused here. Reset only gates the outputs.
            always_comb begin
                raw_out   = 32'h0000_0000;
                valid_out = 1'b0;
                if (rst_n) begin
                    raw_out   = raw_d;
                    valid_out = valid_d;
                end
            end
        end
    endgenerate

    // The polarity is applied last, so the deasserted pattern is all ones when active-low.
    always_comb begin
        m     = ACTIVE_LOW ? ~raw_out : raw_out;
        valid = valid_out;
    end

endmodule

// File: tb/tb_decoder_5to32_reg.sv
// Directed bench for decoder_5to32_reg. It builds three variants on shared inputs:
// the default registered active-high build, a registered active-low build, and a
// combinational active-high build.
module tb_decoder_5to32_reg;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [4:0]  sel;
    logic [31:0] m_reg, m_al, m_cmb;
    logic        valid_reg, valid_al, valid_cmb;

    int n_checks = 0;
    int n_pass   = 0;

    decoder_5to32_reg #(.REGISTERED(1'b1), .ACTIVE_LOW(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sel(sel), .m(m_reg), .valid(valid_reg)
    );

    decoder_5to32_reg #(.REGISTERED(1'b1), .ACTIVE_LOW(1'b1)) u_dut_al (
        .clk(clk), .rst_n(rst_n), .en(en), .sel(sel), .m(m_al), .valid(valid_al)
    );

    decoder_5to32_reg #(.REGISTERED(1'b0), .ACTIVE_LOW(1'b0)) u_dut_cmb (
        .clk(clk), .rst_n(rst_n), .en(en), .sel(sel), .m(m_cmb), .valid(valid_cmb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Drive inputs on the falling edge, away from the sampling edge.
    task automatic drive(input logic e, input logic [4:0] s);
        @(negedge clk);
        en  = e;
        sel = s;
    endtask

    // Sample 1 ns after the rising edge.
    task automatic sample_edge();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] onehot;

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        sel   = 5'd7;

        // Hold reset with en high and sel=7 across two edges.
        sample_edge();
        sample_edge();
        check("rst_m",         m_reg,             32'h0000_0000);
        check("rst_valid",     {31'd0, valid_reg}, 32'd0);
        check("rst_m_al",      m_al,              32'hFFFF_FFFF);
        check("rst_valid_al",  {31'd0, valid_al},  32'd0);
        check("rst_m_cmb",     m_cmb,             32'h0000_0000);
        check("rst_valid_cmb", {31'd0, valid_cmb}, 32'd0);

        // Release reset at a falling edge. The first decode appears at the next rising edge.
        @(negedge clk);
        rst_n = 1'b1;

        // Sweep every sel code. The combinational build updates at once; the registered builds update one edge later.
        for (int s = 0; s < 32; s++) begin
            drive(1'b1, 5'(s));
            onehot = 32'h1 << s;
            #1;
            check($sformatf("cmb_sel%0d", s), m_cmb, onehot);
            sample_edge();
            check($sformatf("reg_sel%0d", s),  m_reg, onehot);
            check($sformatf("al_sel%0d", s),   m_al,  ~onehot);
            check($sformatf("valid_sel%0d", s), {31'd0, valid_reg}, 32'd1);
        end

        // Wrap-around from 31 to 0 on the next clock.
        drive(1'b1, 5'd0);
        sample_edge();
        check("wrap_m", m_reg, 32'h0000_0001);

        // Drop en and change sel at the same edge: en low takes priority.
        drive(1'b0, 5'd19);
        #1;
        check("en0_m_cmb", m_cmb, 32'h0000_0000);
        sample_edge();
        check("en0_m",      m_reg, 32'h0000_0000);
        check("en0_valid",  {31'd0, valid_reg}, 32'd0);
        check("en0_m_al",   m_al,  32'hFFFF_FFFF);
        drive(1'b1, 5'd19);
        sample_edge();
        check("en1_m",      m_reg, 32'h0008_0000);
        check("en1_valid",  {31'd0, valid_reg}, 32'd1);

        // Active-low build with sel=3.
        drive(1'b1, 5'd3);
        sample_edge();
        check("al_sel3", m_al, 32'hFFFF_FFF7);

        // Combinational build: step sel from 10 to 11 between clock edges.
        drive(1'b1, 5'd10);
        #1;
        check("cmb_10", m_cmb, 32'h0000_0400);
        #1;
        sel = 5'd11;
        #1;
        check("cmb_11", m_cmb, 32'h0000_0800);
        check("cmb_valid", {31'd0, valid_cmb}, 32'd1);

        // Assert reset mid-cycle after a decode. The outputs must clear before the next edge.
        drive(1'b1, 5'd12);
        sample_edge();
        check("pre_arst_m", m_reg, 32'h0000_1000);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_m",      m_reg, 32'h0000_0000);
        check("arst_valid",  {31'd0, valid_reg}, 32'd0);
        check("arst_m_al",   m_al,  32'hFFFF_FFFF);
        check("arst_m_cmb",  m_cmb, 32'h0000_0000);

        // After release, decoding resumes at the next rising edge.
        @(negedge clk);
        rst_n = 1'b1;
        sample_edge();
        check("post_rst_m", m_reg, 32'h0000_1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
